// File: rtl/aes128_crypt.sv
// aes128_crypt: iterative AES-128 block cipher, one round per clock, round keys on the fly.
// Rev 1.0 -- define AES_DECRYPT_EN to compile in the decrypt datapath (inverse cipher/key schedule).
`timescale 1ns/1ps
`default_nettype none

module aes128_crypt (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         decrypt,
   input  logic [127:0] msg,
   input  logic [127:0] key,
   input  logic [127:0] w,
   output logic [127:0] cipher,
   output logic         busy,
   output logic         done
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t       state, state_nx;
   logic         load, last;
   logic [127:0] blk, rk, nblk, nrk, ld_key;
   logic [3:0]   rnd;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse; 0 maps to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] y;
      y = x;
      for (int i = 0; i < 6; i++) y = gmul(gmul(y, y), x);
      return gmul(y, y);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = n0 ^ k[95:64];
      n2 = n1 ^ k[63:32];
      n3 = n2 ^ k[31:0];
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
      return {gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
              a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
              a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
              gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
   endfunction

   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic fin);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c+r] = a[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = fin ? {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]}
                                 : mix_col(b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]);
      return o ^ k;
   endfunction

`ifdef AES_DECRYPT_EN
   logic mode_dec;

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   // Walks the expansion backwards: round-r key in, round-(r-1) key out.
   function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                               input logic [7:0] a2, input logic [7:0] a3);
      return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
              gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
              gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
              gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
   endfunction

   function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic fin);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [127:0] t, o;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c+r] = inv_sbox(a[4*((c-r+4)%4)+r]);
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = b[i];
      t = t ^ k;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = fin ? t[127-32*c -: 32]
                                 : inv_mix_col(t[127-32*c -: 8], t[119-32*c -: 8],
                                               t[111-32*c -: 8], t[103-32*c -: 8]);
      return o;
   endfunction

   assign ld_key = decrypt ? w : key;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      mode_dec <= 1'b0;
      else if (load) mode_dec <= decrypt;
   end
`else
   logic unused_dec;
   assign unused_dec = ^{decrypt, w};
   assign ld_key     = key;
`endif

   always_comb begin
      nrk  = fwd_key(rk, rcon(rnd));
      nblk = enc_round(blk, nrk, last);
`ifdef AES_DECRYPT_EN
      if (mode_dec) begin
         nrk  = inv_key(rk, rcon(4'd11 - rnd));
         nblk = dec_round(blk, nrk, last);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: if (start) begin
            load     = 1'b1;
            state_nx = RUN;
         end
         RUN: if (rnd == 4'd10) begin
            last     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk    <= '0;
         rk     <= '0;
         rnd    <= '0;
         cipher <= '0;
         done   <= 1'b0;
      end else begin
         done <= last;
         if (load) begin
            blk <= msg ^ ld_key;
            rk  <= ld_key;
            rnd <= 4'd1;
         end else if (state == RUN) begin
            blk <= nblk;
            rk  <= nrk;
            rnd <= last ? 4'd0 : rnd + 4'd1;
            if (last) cipher <= nblk;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_aes128_crypt.sv
// tb_aes128_crypt: scoreboard bench for aes128_crypt (known-answer vectors, ignored starts, mid-block reset).
`timescale 1ns/1ps
`default_nettype none

module tb_aes128_crypt;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, decrypt;
   logic [127:0] msg, key, w;
   logic [127:0] cipher;
   logic         busy, done;

   int num_checks = 0;
   int num_errors = 0;
   int cycle = 0;

   typedef struct {
      string        tag;
      logic [127:0] exp;
      int           start_edge;
   } exp_t;

   exp_t sb[$];
   exp_t got_e;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

   logic [127:0] enc_key [5] = '{K1, K2, K1, K1, K1};
   logic [127:0] enc_msg [5] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                                 128'h00112233445566778899aabbccddeeff,
                                 128'h3243f6a8885a308d313198a2e0370734,
                                 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                 128'h30c81c46a35ce411e5fbc1191a0a52ef};
   logic [127:0] enc_exp [5] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97,
                                 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                 128'h3925841d02dc09fbdc118597196a0b32,
                                 128'hf5d3d58503b9699de785895a96fdbaaf,
                                 128'h43b1cd7f598ece23881b00e3ed030688};

   aes128_crypt dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .decrypt (decrypt),
      .msg     (msg),
      .key     (key),
      .w       (w),
      .cipher  (cipher),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] junk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one request; returns at the falling edge right after the start edge.
   task automatic issue(input logic dec, input logic [127:0] k, input logic [127:0] wk,
                        input logic [127:0] m, input logic [127:0] exp, input string tag);
      exp_t e;
      @(negedge clk);
      start   = 1'b1;
      decrypt = dec;
      key     = k;
      w       = wk;
      msg     = m;
      e.tag = tag;
      e.exp = exp;
      e.start_edge = cycle + 1;
      sb.push_back(e);
      @(negedge clk);
      start   = 1'b0;
      decrypt = 1'($urandom);
      key     = junk();
      w       = junk();
      msg     = junk();
      check({tag, "_busy"}, 128'(busy), 128'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
      check("drain_timeout", 128'(sb.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 128'(done), 128'd0);
         end else begin
            got_e = sb.pop_front();
            check({got_e.tag, "_cipher"}, cipher, got_e.exp);
            check({got_e.tag, "_latency"}, 128'(cycle - got_e.start_edge), 128'd10);
            check({got_e.tag, "_busy_at_done"}, 128'(busy), 128'd0);
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", num_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; decrypt = 1'b0;
      msg = '0; key = '0; w = '0;
      repeat (2) @(negedge clk);
      check("rst_cipher", cipher, 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      rst = 1'b1;

      // Known-answer encryptions issued back to back (next start at edge N+11).
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, enc_key[i], junk(), enc_msg[i], enc_exp[i], $sformatf("enc%0d", i));
         repeat (9) @(negedge clk);
      end
      drain();
      repeat (3) @(negedge clk);
      check("cipher_hold", cipher, enc_exp[4]);

`ifdef AES_DECRYPT_EN
      issue(1'b1, junk(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
            128'h3ad77bb40d7a3660a89ecaf32466ef97, enc_msg[0], "dec_v1");
      drain();
      issue(1'b1, junk(), 128'h13111d7fe3944a17f307a78b4d2b30c5,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, enc_msg[1], "dec_c1");
      drain();
`else
      issue(1'b1, K1, junk(), enc_msg[0], enc_exp[0], "enconly_dec1");
      drain();
`endif

      // Starts during a running block must be ignored.
      issue(1'b0, enc_key[2], junk(), enc_msg[2], enc_exp[2], "ign");
      repeat (2) @(negedge clk);
      start = 1'b1; key = junk(); msg = junk();
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; key = junk(); msg = junk();
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (4) @(negedge clk);

      // Reset in round 5 aborts the block with no done.
      issue(1'b0, enc_key[3], junk(), enc_msg[3], enc_exp[3], "abort");
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_done", 128'(done), 128'd0);
      check("abort_cipher", cipher, 128'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_result", cipher, 128'd0);
      check("abort_idle", 128'(busy), 128'd0);

      issue(1'b0, enc_key[1], junk(), enc_msg[1], enc_exp[1], "after_abort");
      drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aes128_crypt.md
# aes128_crypt

Iterative AES-128 block cipher core, one round per clock, performing FIPS-197 encryption or decryption of one 128-bit block per request. It is the crypto engine behind the encryption/decryption datapath: the host loads a block and key material, pulses `start`, and collects the result when `done` pulses. Round keys are generated on the fly; no key-expansion RAM is used.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  request pulse; sampled only while idle.
- `decrypt`  in  1  mode, sampled with `start`: 0 = encrypt, 1 = decrypt.
- `msg`  in  128  input block (plaintext or ciphertext), sampled with `start`.
- `key`  in  128  cipher key (round-0 key), used for encryption, sampled with `start`.
- `w`  in  128  round-10 key (last word group of the expansion), used for decryption, sampled with `start`.
- `cipher`  out  128  result block (ciphertext or plaintext).
- `busy`  out  1  high while a block is in progress.
- `done`  out  1  one-cycle pulse when `cipher` is updated.

## Operation
- Byte order: byte 0 = bits [127:120]. State is column-major: bytes 0..3 form column 0.
- Encrypt: state = msg ^ key. Rounds 1-9 apply SubBytes, ShiftRows, MixColumns and AddRoundKey. Round 10 omits MixColumns.
- Forward key step: tmp = SubWord(RotWord(k3)) ^ {Rcon[r],24'h0}; n0=k0^tmp, n1=n0^k1, n2=n1^k2, n3=n2^k3.
- Decrypt: state = msg ^ w. Rounds 1-9 apply InvShiftRows, InvSubBytes, AddRoundKey(previous key) and InvMixColumns. Round 10 omits InvMixColumns.
- Inverse key step from round-r key a0..a3: p3=a3^a2, p2=a2^a1, p1=a1^a0, p0=a0^SubWord(RotWord(p3))^{Rcon[r],24'h0}. Rcon runs from r=10 down to 1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- S-box and inverse S-box are computed combinationally: GF(2^8) inverse modulo 0x11b, plus the affine transform (constant 0x63) or its inverse. Inverse of 0 is 0.
- xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0). InvMixColumns uses the multipliers 9/11/13/14 built from xtime.
- All datapath is 128-bit. No carries; all operations are XOR or GF arithmetic.

## Timing
- Reset values: `cipher`=0, `done`=0, `busy`=0, round counter=0, state and key registers=0.
- `start` is sampled at edge N while `busy`=0. At edge N the core registers the round-0 AddRoundKey result and `busy` goes high.
- Rounds 1..10 execute at edges N+1..N+10.
- At edge N+10: `cipher` is loaded, `done`=1 for exactly one cycle, and `busy`=0.
- Latency is 10 clocks from the start edge to `done`. Throughput is one block per 11 cycles; back-to-back `start` at edge N+11 is legal.
- `start` while `busy`=1 is ignored. Inputs may change freely after the start edge.
- `cipher` holds its value until the next `done`.
- Reset asserted mid-operation aborts the block immediately. All outputs return to their reset values and no `done` is produced.
- FSM states:
  - IDLE → RUN on `start`.
  - RUN counts rounds 1..10; round 10 → IDLE, asserting `done`.

## Configuration
- `AES_DECRYPT_EN` defined: the decrypt datapath (inverse S-box, InvMixColumns, inverse key schedule) is compiled in and `decrypt` is honoured.
- Not defined: encrypt-only core. `decrypt` and `w` are ignored, and every request is encrypted.

## Test plan
- Encrypt with key 2b7e151628aed2a6abf7158809cf4f3c, msg 6bc1bee22e409f96e93d7e117393172a → `cipher` 3ad77bb40d7a3660a89ecaf32466ef97, `done` at start edge + 10.
- Decrypt with w d014f9a8c9ee2589e13f0cc8b6630ca6, msg 3ad77bb40d7a3660a89ecaf32466ef97 → `cipher` 6bc1bee22e409f96e93d7e117393172a.
- FIPS-197 C.1 encrypt with key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Then decrypt with w 13111d7fe3944a17f307a78b4d2b30c5 → original msg.
- Pulse `start` again at cycles 3 and 7 of a running block → ignored; a single `done` with the first block's result.
- Assert `rst` at round 5 → `busy`, `done` and `cipher` are 0 at once, no `done` follows, and the next `start` completes normally.
- Build without `AES_DECRYPT_EN` and pulse `start` with `decrypt`=1 on vector 1 → encryption result 3ad77bb40d7a3660a89ecaf32466ef97.
